// File: rtl/hpm_counter_bank.sv
// Performance-monitor counter bank: per-counter event select, inhibit, sticky overflow
// and overflow interrupt, with a single register stage on the event inputs.
module hpm_counter_bank #(
  parameter int unsigned NumCounters  = 8,
  parameter int unsigned CounterWidth = 64,
  parameter int unsigned DataWidth    = 64,
  parameter int unsigned NumEvents    = 32,
  parameter int unsigned IncWidth     = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            clr_i,
  input  logic                            debug_mode_i,
  input  logic [5:0]                      addr_i,
  input  logic                            we_i,
  input  logic [DataWidth-1:0]            data_i,
  output logic [DataWidth-1:0]            data_o,
  input  logic [NumEvents*IncWidth-1:0]   events_i,
  output logic                            ovf_irq_o
);

  localparam int unsigned EvWidth  = NumEvents * IncWidth;
  localparam int unsigned SumWidth = CounterWidth + 1;

  logic [EvWidth-1:0]      r_ev_q;
  logic [CounterWidth-1:0] r_cnt   [NumCounters];
  logic [CounterWidth-1:0] w_cnt_d [NumCounters];
  logic [7:0]              r_sel   [NumCounters];
  logic [7:0]              w_sel_d [NumCounters];
  logic [NumCounters-1:0]  r_inh, r_of, r_oie;
  logic [NumCounters-1:0]  w_inh_d, w_of_d, w_oie_d;
  logic [NumCounters-1:0]  w_wr_cnt, w_wr_ctl;
  logic [IncWidth-1:0]     w_inc   [NumCounters];
  logic [SumWidth-1:0]     w_sum   [NumCounters];
  logic [10:0]             w_ctrl  [NumCounters];

  // Indices at or above NumCounters never match, so such writes fall away.
  always_comb begin
    w_wr_cnt = '0;
    w_wr_ctl = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (we_i && (addr_i[4:0] == 5'(i))) begin
        w_wr_cnt[i] = ~addr_i[5];
        w_wr_ctl[i] = addr_i[5];
      end
    end
  end

  // SEL of 0 or above NumEvents matches no source and yields a zero increment.
  always_comb begin
    for (int i = 0; i < NumCounters; i++) begin
      w_inc[i] = '0;
      for (int k = 0; k < NumEvents; k++) begin
        if (r_sel[i] == 8'(k + 1)) begin
          w_inc[i] = r_ev_q[k*IncWidth +: IncWidth];
        end
      end
      w_sum[i]  = {1'b0, r_cnt[i]} + SumWidth'(w_inc[i]);
      w_ctrl[i] = {r_oie[i], r_of[i], r_inh[i], r_sel[i]};
    end
  end

  // Any register write to a counter drops that counter's increment for the cycle.
  always_comb begin
    w_inh_d = r_inh;
    w_of_d  = r_of;
    w_oie_d = r_oie;
    for (int i = 0; i < NumCounters; i++) begin
      w_cnt_d[i] = r_cnt[i];
      w_sel_d[i] = r_sel[i];
      if (w_wr_cnt[i]) begin
        w_cnt_d[i] = data_i[CounterWidth-1:0];
      end else if (w_wr_ctl[i]) begin
        w_sel_d[i] = data_i[7:0];
        w_inh_d[i] = data_i[8];
        w_of_d[i]  = data_i[9];
        w_oie_d[i] = data_i[10];
      end else if (!r_inh[i]) begin
        w_cnt_d[i] = w_sum[i][CounterWidth-1:0];
        if (w_sum[i][CounterWidth]) begin
          w_of_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int i = 0; i < NumCounters; i++) begin
      if (addr_i[4:0] == 5'(i)) begin
        data_o = addr_i[5] ? DataWidth'(w_ctrl[i]) : DataWidth'(r_cnt[i]);
      end
    end
  end

  assign ovf_irq_o = |(r_of & r_oie);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ev_q <= '0;
      r_inh  <= '0;
      r_of   <= '0;
      r_oie  <= '0;
      for (int i = 0; i < NumCounters; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= '0;
      end
    end else if (clr_i) begin
      r_ev_q <= '0;
      r_inh  <= '0;
      r_of   <= '0;
      r_oie  <= '0;
      for (int i = 0; i < NumCounters; i++) begin
        r_cnt[i] <= '0;
        r_sel[i] <= '0;
      end
    end else begin
      r_ev_q <= debug_mode_i ? '0 : events_i;
      r_inh  <= w_inh_d;
      r_of   <= w_of_d;
      r_oie  <= w_oie_d;
      for (int i = 0; i < NumCounters; i++) begin
        r_cnt[i] <= w_cnt_d[i];
        r_sel[i] <= w_sel_d[i];
      end
    end
  end

endmodule
